cpu_program_loader: RTL
=======================

// Module: cpu_program_loader
// PURPOSE
//  Upstream stage of the 5-bit CPU: accepts instruction words over a valid/ready stream and writes them into program RAM.
//  Drives the CPU's RAM write port (data/address/enable), holds the CPU in reset while loading, then releases it.
//  After release, gates PC_Enable in free-run or single-step mode. Abort returns to idle at any time.
// PARAMETERS
//  DATA_W  11  instruction word width; equals the RAM row width
//  ADDR_W  3   program RAM address width
//  DEPTH   8   program RAM rows; must equal 2**ADDR_W
// PORTS
//  clk          in   1       system clock, shared with the CPU
//  reset        in   1       asynchronous, active-low reset
//  start        in   1       level; begins a load when sampled high in IDLE
//  abort        in   1       level; forces IDLE from any state
//  load_len     in   ADDR_W  number of words to load; 0 means DEPTH; sampled on start
//  s_valid      in   1       stream word valid
//  s_data       in   DATA_W  stream instruction word
//  s_ready      out  1       loader can accept s_data this cycle
//  run_mode     in   1       1 = free-run, 0 = single-step
//  step         in   1       single-step request; rising edge is significant
//  ram_wr_en    out  1       RAM_Write_Enable to the CPU
//  ram_wr_addr  out  ADDR_W  RAM_Write_Address to the CPU
//  ram_wr_data  out  DATA_W  RAM_Write_Data to the CPU
//  cpu_reset    out  1       active-high reset to the CPU core
//  pc_enable    out  1       PC_Enable to the CPU
//  busy         out  1       high in LOAD and HOLD
//  run_cycles   out  8       enabled CPU cycles since RUN entry; saturates at 255
// BEHAVIOUR
//  Reset (reset=0): state=IDLE; cpu_reset=1; all other outputs 0; word counter=0; step history=0.
//  States: IDLE -> LOAD -> HOLD -> RUN. abort (highest priority) -> IDLE on the next edge, from every state.
//  IDLE:
//   - cpu_reset=1, pc_enable=0, s_ready=0.
//   - start=1 -> LOAD. Latch len = (load_len==0) ? DEPTH : load_len. Clear counter.
//  LOAD:
//   - s_ready = (state==LOAD) & ~abort. This is combinational, so no word is accepted in an abort cycle.
//   - An accept is s_valid & s_ready. The next cycle: ram_wr_en=1, ram_wr_addr=counter, ram_wr_data=s_data (registered, latency 1).
//   - Counter increments per accept. The accept that brings counter to len -> HOLD.
//   - Addresses never exceed DEPTH-1. No wrap.
//   - start is ignored outside IDLE.
//  HOLD:
//   - Exactly 2 cycles, with cpu_reset=1 and s_ready=0.
//   - The last write completes during the first HOLD cycle. ram_wr_en=0 thereafter.
//   - Then -> RUN with cpu_reset=0 and run_cycles=0.
//  RUN:
//   - cpu_reset=0. Leave only via abort.
//   - Free-run: pc_enable=1 continuously.
//   - Single-step: each 0->1 transition of step (history flop) gives exactly one pc_enable cycle.
//   - A step edge while run_mode=1 is ignored.
//   - A run_mode change takes effect on the next cycle.
//   - run_cycles increments on every cycle with pc_enable=1.
//  pc_enable retiming (glitch-free):
//   - The CPU gates its clock as clk & PC_Enable.
//   - Compute the internal enable on the rising edge, then retime it through a falling-edge flop that drives pc_enable.
//   - pc_enable therefore never changes while clk is high.
//   - The falling-edge flop also resets asynchronously to 0.
//  Abort:
//   - Next cycle: state=IDLE, cpu_reset=1, ram_wr_en=0, pc_enable=0 (after the falling edge).
//   - A write already registered is cancelled. RAM contents are left as-is.
//  reset mid-LOAD or mid-RUN: same as power-on reset. A partially loaded RAM is not cleared.
//  ram_wr_addr and ram_wr_data hold their last value when ram_wr_en=0.
// STRUCTURE
//  Shared package cpu5_loader_pkg:
//   - state enum: IDLE=2'd0, LOAD=2'd1, HOLD=2'd2, RUN=2'd3
//   - DATA_W, ADDR_W, DEPTH defaults
//   - HOLD_CYCLES=2, RUN_CNT_MAX=8'd255
//  One sub-module, cpu_step_gate: step edge detect, free-run/step select, falling-edge pc_enable retime, run_cycles counter.
//  Top level: FSM, word counter, stream handshake, RAM write registers.
// TESTING
//  1. Release reset, start with load_len=3, stream 11'h101, 11'h202, 11'h303 back-to-back.
//     -> writes at addr 0, 1, 2, each 1 cycle after its accept; 2 HOLD cycles; cpu_reset falls; pc_enable=1 (run_mode=1).
//  2. load_len=0, 8 words with s_valid toggling every other cycle.
//     -> exactly 8 writes at addr 0..7; s_ready=0 in HOLD; no write to addr 0 again.
//  3. RUN with run_mode=0, step pulsed 3 times (each high 4 cycles).
//     -> exactly 3 single-cycle pc_enable pulses; run_cycles=3.
//     -> pc_enable edges coincide only with clk falling edges.
//  4. abort in the same cycle as s_valid during LOAD (2nd word).
//     -> s_ready=0 that cycle; no write of that word; IDLE next; cpu_reset=1.
//  5. Assert reset mid-RUN with run_cycles=40.
//     -> outputs immediately: cpu_reset=1, pc_enable=0, run_cycles=0.
//     -> a new start reloads from addr 0.
//  6. Free-run for 300 cycles -> run_cycles saturates at 255 and holds.

Source files
------------

// File: rtl/cpu5_loader_pkg.sv
// Shared definitions for the 5-bit CPU program loader.
//   state_e      : loader FSM states
//   DATA_W       : default instruction word width (equals RAM row width)
//   ADDR_W       : default program RAM address width
//   DEPTH        : default program RAM rows (2**ADDR_W)
//   HOLD_CYCLES  : cycles the CPU stays in reset after the last word
//   RUN_CNT_MAX  : saturation value of the run_cycles counter
package cpu5_loader_pkg;

    localparam int DATA_W      = 11;
    localparam int ADDR_W      = 3;
    localparam int DEPTH       = 8;
    localparam int HOLD_CYCLES = 2;

    localparam logic [7:0] RUN_CNT_MAX = 8'd255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } state_e;

endpackage

// File: rtl/cpu_step_gate.sv
// PC enable generation for the loaded CPU.
//   clk        in  : system clock
//   reset      in  : asynchronous, active-low reset
//   run_next   in  : loader will be in RUN during the next cycle
//   run_mode   in  : 1 = free-run, 0 = single-step
//   step       in  : single-step request, rising edge significant
//   pc_enable  out : PC_Enable to the CPU, changes only on clk falling edges
//   run_cycles out : enabled CPU cycles since RUN entry, saturating
module cpu_step_gate (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_next,
    input  logic       run_mode,
    input  logic       step,
    output logic       pc_enable,
    output logic [7:0] run_cycles
);
    import cpu5_loader_pkg::*;

    logic       step_q, step_d;
    logic       en_q, en_d;
    logic [7:0] run_cycles_q, run_cycles_d;
    logic       pc_enable_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        step_d       = step;
        run_cycles_d = run_cycles_q;

        // Step edges are only meaningful in single-step mode; in free-run
        // the enable is simply held high.
        en_d = run_next && (run_mode || (step && !step_q));

        // Each en_q cycle becomes exactly one pc_enable window, so counting
        // en_q counts enabled CPU cycles.
        if (!run_next) begin
            run_cycles_d = '0;
        end else if (en_q && (run_cycles_q != RUN_CNT_MAX)) begin
            run_cycles_d = run_cycles_q + 8'd1;
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_q       <= 1'b0;
            en_q         <= 1'b0;
            run_cycles_q <= '0;
        end else begin
            step_q       <= step_d;
            en_q         <= en_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    // The CPU gates its clock as clk & pc_enable. Retiming on the falling
    // edge keeps pc_enable stable for the whole high phase of clk, so the
    // gated clock can never glitch.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            pc_enable_q <= 1'b0;
        end else begin
            pc_enable_q <= en_q;
        end
    end

    assign pc_enable  = pc_enable_q;
    assign run_cycles = run_cycles_q;

endmodule

// File: rtl/cpu_program_loader.sv
// Program loader for the 5-bit CPU: streams instruction words into program
// RAM, holds the CPU in reset while loading, then releases it and gates its
// PC enable in free-run or single-step mode.
//   clk, reset     : system clock, asynchronous active-low reset
//   start, abort   : begin a load (in IDLE) / force IDLE from any state
//   load_len       : words to load, 0 means DEPTH; sampled on start
//   s_valid/s_data/s_ready : instruction word stream
//   run_mode, step : free-run / single-step control
//   ram_wr_en/addr/data : CPU RAM write port, registered
//   cpu_reset      : active-high CPU core reset
//   pc_enable      : PC_Enable to the CPU
//   busy           : high in LOAD and HOLD
//   run_cycles     : enabled CPU cycles since RUN entry, saturating at 255
module cpu_program_loader #(
    parameter int DATA_W = cpu5_loader_pkg::DATA_W,
    parameter int ADDR_W = cpu5_loader_pkg::ADDR_W,
    parameter int DEPTH  = cpu5_loader_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    input  logic              run_mode,
    input  logic              step,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              cpu_reset,
    output logic              pc_enable,
    output logic              busy,
    output logic [7:0]        run_cycles
);
    import cpu5_loader_pkg::*;

    // One extra bit so a full-depth load length is representable.
    localparam int CNT_W = ADDR_W + 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        hold_cnt_q, hold_cnt_d;
    logic              ram_wr_en_q, ram_wr_en_d;
    logic [ADDR_W-1:0] ram_wr_addr_q, ram_wr_addr_d;
    logic [DATA_W-1:0] ram_wr_data_q, ram_wr_data_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              busy_q, busy_d;
    logic              accept;
    logic              run_next;

    // Combinational so an abort blocks the handshake in the same cycle.
    assign s_ready = (state_q == LOAD) && !abort;
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        count_d       = count_q;
        hold_cnt_d    = hold_cnt_q;
        ram_wr_en_d   = accept;
        ram_wr_addr_d = ram_wr_addr_q;
        ram_wr_data_d = ram_wr_data_q;

        // Address and data only move on an accept, so they hold their last
        // value whenever the write enable is low.
        if (accept) begin
            ram_wr_addr_d = count_q[ADDR_W-1:0];
            ram_wr_data_d = s_data;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    len_d   = (load_len == '0) ? CNT_W'(DEPTH) : {1'b0, load_len};
                    count_d = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    count_d = count_q + CNT_W'(1);
                    if (count_d == len_q) begin
                        state_d    = HOLD;
                        hold_cnt_d = '0;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt_q == 2'(HOLD_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 2'd1;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
        end

        // Outputs are decoded from the next state so they are registered
        // alongside it and change on the same edge.
        cpu_reset_d = (state_d != RUN);
        busy_d      = (state_d == LOAD) || (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            len_q         <= '0;
            count_q       <= '0;
            hold_cnt_q    <= '0;
            ram_wr_en_q   <= 1'b0;
            ram_wr_addr_q <= '0;
            ram_wr_data_q <= '0;
            cpu_reset_q   <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            count_q       <= count_d;
            hold_cnt_q    <= hold_cnt_d;
            ram_wr_en_q   <= ram_wr_en_d;
            ram_wr_addr_q <= ram_wr_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
            cpu_reset_q   <= cpu_reset_d;
            busy_q        <= busy_d;
        end
    end

    assign run_next = (state_d == RUN);

    cpu_step_gate u_step_gate (
        .clk        (clk),
        .reset      (reset),
        .run_next   (run_next),
        .run_mode   (run_mode),
        .step       (step),
        .pc_enable  (pc_enable),
        .run_cycles (run_cycles)
    );

    assign ram_wr_en   = ram_wr_en_q;
    assign ram_wr_addr = ram_wr_addr_q;
    assign ram_wr_data = ram_wr_data_q;
    assign cpu_reset   = cpu_reset_q;
    assign busy        = busy_q;

endmodule
